// File: rtl/elelock_pkg.sv
// Shared definitions for the electronic lock: key indices, the PIN-entry
// controller state encoding and the BCD digit type.
package elelock_pkg;

  localparam int unsigned NKEYS   = 12;
  localparam int unsigned KEY_CLR = 10;
  localparam int unsigned KEY_ENT = 11;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    StLocked,
    StCheck,
    StOpen,
    StLockout
  } state_e;

endpackage

// File: rtl/key_decode.sv
// Combinational key decoder: checks that exactly one key pulse is active and
// encodes it. Also used by the display driver.
//   key_pulse_i : one pulse bit per key (0-9 digits, 10 CLR, 11 ENT)
//   valid_o     : exactly one bit of key_pulse_i is set
//   is_digit_o  : valid digit key
//   is_clr_o    : valid CLR key
//   is_ent_o    : valid ENT key
//   digit_o     : BCD value of the digit key (0 when not a digit)
module key_decode
  import elelock_pkg::*;
(
  input  logic [NKEYS-1:0] key_pulse_i,
  output logic             valid_o,
  output logic             is_digit_o,
  output logic             is_clr_o,
  output logic             is_ent_o,
  output bcd_t             digit_o
);

  logic       onehot;
  logic [3:0] idx;

  always_comb begin
    // x & (x - 1) clears the lowest set bit; zero afterwards means at most one bit
    onehot = (key_pulse_i != '0) &&
             ((key_pulse_i & (key_pulse_i - NKEYS'(1))) == '0);
    idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (key_pulse_i[i]) idx = 4'(i);
    end
    valid_o    = onehot;
    is_clr_o   = onehot && key_pulse_i[KEY_CLR];
    is_ent_o   = onehot && key_pulse_i[KEY_ENT];
    is_digit_o = onehot && (key_pulse_i[9:0] != '0);
    digit_o    = is_digit_o ? idx : '0;
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// PIN-entry controller for the electronic lock. Collects a DIGITS-long BCD code,
// compares it with the stored PIN, drives the lock, counts failed attempts and
// enforces a timed lockout. The PIN can be changed while the lock is open.
// Optional build macro ELELOCK_AUTOLOCK_EN: relock after AUTOLOCK_CYC idle
// cycles in the open state.
//   CLK           : clock
//   RST           : asynchronous active-low reset
//   key_pulse     : one-cycle key pulses (0-9 digits, 10 CLR, 11 ENT)
//   unlocked      : lock actuator drive, high while open
//   alarm         : high during lockout
//   err_pulse     : one-cycle pulse on a rejected entry or mismatch
//   pin_set_pulse : one-cycle pulse when a new PIN is stored
//   digit_cnt     : digits currently buffered
//   entry         : entry buffer, last digit in the LSB nibble
module key_entry_ctrl
  import elelock_pkg::*;
#(
  parameter int unsigned         DIGITS       = 4,
  parameter logic [4*DIGITS-1:0] PIN_INIT     = 16'h1234,
  parameter int unsigned         MAX_FAIL     = 3,
  parameter int unsigned         LOCKOUT_CYC  = 1000,
  parameter int unsigned         AUTOLOCK_CYC = 5000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NKEYS-1:0]    key_pulse,
  output logic                unlocked,
  output logic                alarm,
  output logic                err_pulse,
  output logic                pin_set_pulse,
  output logic [3:0]          digit_cnt,
  output logic [4*DIGITS-1:0] entry
);

  localparam int unsigned EntryW  = 4 * DIGITS;
  localparam int unsigned LkW     = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [LkW-1:0] LkLoad = LkW'(LOCKOUT_CYC - 1);
  localparam logic [3:0]  DigitsC  = 4'(DIGITS);
  localparam logic [3:0]  MaxFailC = 4'(MAX_FAIL);

  logic kd_valid, kd_is_digit, kd_is_clr, kd_is_ent;
  bcd_t kd_digit;

  key_decode u_key_decode (
    .key_pulse_i (key_pulse),
    .valid_o     (kd_valid),
    .is_digit_o  (kd_is_digit),
    .is_clr_o    (kd_is_clr),
    .is_ent_o    (kd_is_ent),
    .digit_o     (kd_digit)
  );

  state_e            state_q, state_d;
  logic [EntryW-1:0] entry_q, entry_d;
  logic [EntryW-1:0] pin_q, pin_d;
  logic [3:0]        digit_cnt_q, digit_cnt_d;
  logic [3:0]        fail_cnt_q, fail_cnt_d;
  logic [LkW-1:0]    lk_tmr_q, lk_tmr_d;
  logic              unlocked_q, unlocked_d;
  logic              alarm_q, alarm_d;
  logic              err_q, err_d;
  logic              pin_set_q, pin_set_d;

`ifdef ELELOCK_AUTOLOCK_EN
  localparam int unsigned AlW = (AUTOLOCK_CYC > 1) ? $clog2(AUTOLOCK_CYC) : 1;
  localparam logic [AlW-1:0] AlLoad = AlW'(AUTOLOCK_CYC - 1);
  logic [AlW-1:0] auto_tmr_q, auto_tmr_d;
`endif

  logic full, digit_ok;

  always_comb begin
    full     = (digit_cnt_q == DigitsC);
    digit_ok = kd_is_digit && (digit_cnt_q < DigitsC);

    state_d     = state_q;
    entry_d     = entry_q;
    pin_d       = pin_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    lk_tmr_d    = lk_tmr_q;
    err_d       = 1'b0;
    pin_set_d   = 1'b0;
    // Status outputs trail the state by one register stage
    unlocked_d  = (state_q == StOpen);
    alarm_d     = (state_q == StLockout);
`ifdef ELELOCK_AUTOLOCK_EN
    auto_tmr_d  = auto_tmr_q;
`endif

    unique case (state_q)
      StLocked: begin
        if (kd_valid) begin
          if (digit_ok) begin
            entry_d     = (entry_q << 4) | EntryW'(kd_digit);
            digit_cnt_d = digit_cnt_q + 4'd1;
          end else if (kd_is_clr) begin
            entry_d     = '0;
            digit_cnt_d = '0;
          end else if (kd_is_ent) begin
            if (full) begin
              state_d = StCheck;
            end else begin
              // Short entry: rejected without counting as a failed attempt
              err_d       = 1'b1;
              entry_d     = '0;
              digit_cnt_d = '0;
            end
          end
        end
      end

      StCheck: begin
        entry_d     = '0;
        digit_cnt_d = '0;
        if (entry_q == pin_q) begin
          state_d    = StOpen;
          fail_cnt_d = '0;
`ifdef ELELOCK_AUTOLOCK_EN
          auto_tmr_d = AlLoad;
`endif
        end else begin
          err_d      = 1'b1;
          fail_cnt_d = fail_cnt_q + 4'd1;
          if (fail_cnt_d == MaxFailC) begin
            state_d  = StLockout;
            lk_tmr_d = LkLoad;
          end else begin
            state_d = StLocked;
          end
        end
      end

      StOpen: begin
        if (kd_valid) begin
          if (digit_ok) begin
            entry_d     = (entry_q << 4) | EntryW'(kd_digit);
            digit_cnt_d = digit_cnt_q + 4'd1;
          end else if (kd_is_clr) begin
            if (digit_cnt_q != '0) begin
              entry_d     = '0;
              digit_cnt_d = '0;
            end else begin
              state_d = StLocked;
            end
          end else if (kd_is_ent) begin
            if (full) begin
              pin_d     = entry_q;
              pin_set_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            entry_d     = '0;
            digit_cnt_d = '0;
          end
        end
`ifdef ELELOCK_AUTOLOCK_EN
        // A key in the expiry cycle reloads the timer and keeps the lock open
        if (kd_valid) begin
          auto_tmr_d = AlLoad;
        end else if (auto_tmr_q == '0) begin
          state_d     = StLocked;
          entry_d     = '0;
          digit_cnt_d = '0;
        end else begin
          auto_tmr_d = auto_tmr_q - AlW'(1);
        end
`endif
      end

      StLockout: begin
        if (lk_tmr_q == '0) begin
          state_d    = StLocked;
          fail_cnt_d = '0;
        end else begin
          lk_tmr_d = lk_tmr_q - LkW'(1);
        end
      end

      default: state_d = StLocked;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StLocked;
      entry_q     <= '0;
      pin_q       <= PIN_INIT;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      lk_tmr_q    <= '0;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
      pin_set_q   <= 1'b0;
`ifdef ELELOCK_AUTOLOCK_EN
      auto_tmr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      pin_q       <= pin_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      lk_tmr_q    <= lk_tmr_d;
      unlocked_q  <= unlocked_d;
      alarm_q     <= alarm_d;
      err_q       <= err_d;
      pin_set_q   <= pin_set_d;
`ifdef ELELOCK_AUTOLOCK_EN
      auto_tmr_q  <= auto_tmr_d;
`endif
    end
  end

  assign unlocked      = unlocked_q;
  assign alarm         = alarm_q;
  assign err_pulse     = err_q;
  assign pin_set_pulse = pin_set_q;
  assign digit_cnt     = digit_cnt_q;
  assign entry         = entry_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed key sequences, a queue-based reference
// model compared every cycle, plus literal expectations at key points.
module tb_key_entry_ctrl;

  localparam int Digits  = 4;
  localparam int MaxFail = 3;
  localparam int LockCyc = 8;
  localparam int AutoCyc = 16;

  localparam int MLocked  = 0;
  localparam int MCheck   = 1;
  localparam int MOpen    = 2;
  localparam int MLockout = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] key_pulse = '0;
  logic        unlocked, alarm, err_pulse, pin_set_pulse;
  logic [3:0]  digit_cnt;
  logic [15:0] entry;

  int n_vec = 0;
  int n_err = 0;
  int alarm_cyc = 0;
  int err_seen = 0;
  int err0;

  always #5 CLK = ~CLK;

  key_entry_ctrl #(
    .DIGITS       (Digits),
    .PIN_INIT     (16'h1234),
    .MAX_FAIL     (MaxFail),
    .LOCKOUT_CYC  (LockCyc),
    .AUTOLOCK_CYC (AutoCyc)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .key_pulse     (key_pulse),
    .unlocked      (unlocked),
    .alarm         (alarm),
    .err_pulse     (err_pulse),
    .pin_set_pulse (pin_set_pulse),
    .digit_cnt     (digit_cnt),
    .entry         (entry)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode = MLocked;
  int          m_q[$];
  logic [15:0] m_pin = 16'h1234;
  int          m_fails = 0, m_lk = 0, m_idle = 0;
  logic        e_unl = 0, e_alm = 0, e_err = 0, e_pset = 0;
  int          mk, mprev;
  bit          mv, merr, mpset;

  function automatic logic [15:0] q_val();
    logic [15:0] v = '0;
    foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
    return v;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_mode = MLocked; m_q.delete(); m_pin = 16'h1234;
      m_fails = 0; m_lk = 0; m_idle = 0;
      e_unl = 0; e_alm = 0; e_err = 0; e_pset = 0;
    end else begin
      mv = ($countones(key_pulse) == 1);
      mk = 0;
      for (int i = 0; i < 12; i++) if (key_pulse[i]) mk = i;
      mprev = m_mode; merr = 0; mpset = 0;
      case (m_mode)
        MLocked: if (mv) begin
          if (mk < 10) begin
            if (m_q.size() < Digits) m_q.push_back(mk);
          end else if (mk == 10) m_q.delete();
          else if (m_q.size() == Digits) m_mode = MCheck;
          else begin merr = 1; m_q.delete(); end
        end
        MCheck: begin
          if (q_val() == m_pin) begin
            m_mode = MOpen; m_fails = 0; m_idle = 0;
          end else begin
            merr = 1; m_fails++;
            if (m_fails == MaxFail) begin m_mode = MLockout; m_lk = LockCyc; end
            else m_mode = MLocked;
          end
          m_q.delete();
        end
        MOpen: begin
          if (mv) begin
            if (mk < 10) begin
              if (m_q.size() < Digits) m_q.push_back(mk);
            end else if (mk == 10) begin
              if (m_q.size() > 0) m_q.delete(); else m_mode = MLocked;
            end else begin
              if (m_q.size() == Digits) begin m_pin = q_val(); mpset = 1; end
              else merr = 1;
              m_q.delete();
            end
          end
`ifdef ELELOCK_AUTOLOCK_EN
          if (m_mode == MOpen) begin
            if (mv) m_idle = 0;
            else begin
              m_idle++;
              if (m_idle == AutoCyc) begin m_mode = MLocked; m_q.delete(); end
            end
          end
`endif
        end
        default: begin
          m_lk--;
          if (m_lk == 0) begin m_mode = MLocked; m_fails = 0; end
        end
      endcase
      e_unl = (mprev == MOpen); e_alm = (mprev == MLockout);
      e_err = merr; e_pset = mpset;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    chk("unlocked", int'(unlocked), int'(e_unl));
    chk("alarm", int'(alarm), int'(e_alm));
    chk("err_pulse", int'(err_pulse), int'(e_err));
    chk("pin_set_pulse", int'(pin_set_pulse), int'(e_pset));
    chk("digit_cnt", int'(digit_cnt), m_q.size());
    chk("entry", int'(entry), int'(q_val()));
    if (alarm === 1'b1) alarm_cyc++;
    if (err_pulse === 1'b1) err_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [11:0] v);
    key_pulse = v;
    @(posedge CLK); #1;
    key_pulse = '0;
  endtask

  task automatic press(input int k);
    drive(12'(1 << k));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d); press(11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    #2 RST = 1'b0;
    step(2);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_err", int'(err_pulse), 0);
    chk("rst_pset", int'(pin_set_pulse), 0);
    chk("rst_cnt", int'(digit_cnt), 0);
    chk("rst_entry", int'(entry), 0);
    RST = 1'b1;
    step(1);

    // Correct code: unlocked two edges after ENT
    err0 = err_seen;
    press(1); press(2); press(3); press(4);
    chk("entry_1234", int'(entry), 16'h1234);
    chk("cnt_full", int'(digit_cnt), 4);
    press(11);
    chk("unl_in_check", int'(unlocked), 0);
    step(1);
    chk("unl_edge1", int'(unlocked), 0);
    step(1);
    chk("unl_edge2", int'(unlocked), 1);
    chk("no_err_on_match", err_seen - err0, 0);
    press(10); step(1);
    chk("relock_clr", int'(unlocked), 0);

    // Short entry
    err0 = err_seen;
    press(1); press(2); press(11);
    chk("short_err", int'(err_pulse), 1);
    chk("short_cnt", int'(digit_cnt), 0);
    code(1, 2, 3, 4); step(2);
    chk("unl_after_short", int'(unlocked), 1);
    chk("short_err_count", err_seen - err0, 1);
    press(10); step(1);

    // Three mismatches -> lockout of LockCyc cycles, keys ignored meanwhile
    err0 = err_seen;
    alarm_cyc = 0;
    for (int a = 0; a < 3; a++) begin
      code(9, 9, 9, 9); step(1);
    end
    code(1, 2, 3, 4);
    chk("lockout_alarm", int'(alarm), 1);
    chk("lockout_entry", int'(entry), 0);
    chk("lockout_cnt", int'(digit_cnt), 0);
    for (int i = 0; i < 30 && alarm === 1'b1; i++) step(1);
    chk("alarm_ends", int'(alarm), 0);
    chk("alarm_cycles", alarm_cyc, 8);
    chk("mismatch_errs", err_seen - err0, 3);
    chk("unl_in_lockout", int'(unlocked), 0);
    code(1, 2, 3, 4); step(2);
    chk("unl_after_lockout", int'(unlocked), 1);
    press(10); step(1);

    // Multi-bit pulses ignored, buffer does not wrap
    drive(12'h003);
    drive(12'hC00);
    chk("multi_cnt", int'(digit_cnt), 0);
    chk("multi_entry", int'(entry), 0);
    press(1); press(2); press(3); press(4); press(5);
    chk("nowrap_entry", int'(entry), 16'h1234);
    chk("nowrap_cnt", int'(digit_cnt), 4);
    press(10);

    // PIN change
    code(1, 2, 3, 4); step(2);
    chk("unl_for_pinset", int'(unlocked), 1);
    code(5, 6, 7, 8);
    chk("pin_set", int'(pin_set_pulse), 1);
    chk("pin_set_cnt", int'(digit_cnt), 0);
    press(10); press(10); step(1);
    chk("locked_after_clr", int'(unlocked), 0);
    code(1, 2, 3, 4); step(1);
    chk("old_pin_rejected", int'(err_pulse), 1);
    code(5, 6, 7, 8); step(2);
    chk("new_pin_opens", int'(unlocked), 1);

    // Reset mid-entry restores PIN_INIT
    press(1); press(2);
    chk("partial_cnt", int'(digit_cnt), 2);
    RST = 1'b0; #1;
    chk("rst_mid_entry", int'(entry), 0);
    chk("rst_mid_cnt", int'(digit_cnt), 0);
    chk("rst_mid_unl", int'(unlocked), 0);
    RST = 1'b1;
    code(5, 6, 7, 8); step(1);
    chk("pin_restored", int'(err_pulse), 1);

    // Reset during lockout
    code(9, 9, 9, 9); step(1);
    code(9, 9, 9, 9); step(2);
    chk("lockout2_alarm", int'(alarm), 1);
    RST = 1'b0; #1;
    chk("rst_lockout_alarm", int'(alarm), 0);
    chk("rst_lockout_err", int'(err_pulse), 0);
    RST = 1'b1;
    code(1, 2, 3, 4); step(2);
    chk("unl_after_rst", int'(unlocked), 1);

    // Idle in OPEN: relock after AutoCyc cycles only when the feature is built
    step(15);
    chk("idle_edge16", int'(unlocked), 1);
    step(1);
`ifdef ELELOCK_AUTOLOCK_EN
    chk("autolock", int'(unlocked), 0);
`else
    chk("no_autolock", int'(unlocked), 1);
`endif
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
